regs_port_arb: RTL and testbench
================================

# regs_port_arb

Sequencer and arbiter for the general-purpose register file's single write port and debug read port. After reset it zero-fills the file. It then shares the write port between the execute-stage write-back (fixed priority) and the JTAG debug module through a 4-phase req/ack handshake. If debug traffic is starved, it raises a pipeline hold. It sits between ex/jtag and the register file; the register file's own read ports to id are unaffected.

## Interface
- ADDR_W, 5, register address width
- DATA_W, 32, register data width
- NUM_REGS, 32, number of registers; x0 is never written
- STARVE_MAX, 4, cycles a pending JTAG op may lose to ex before hold_o asserts (1..15)

- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- ex_we_i  in  1  ex write enable
- ex_waddr_i  in  ADDR_W  ex write address
- ex_wdata_i  in  DATA_W  ex write data
- jtag_req_i  in  1  debug request, level, held until jtag_ack_o seen
- jtag_we_i  in  1  1 = write, 0 = read; sampled with request
- jtag_addr_i  in  ADDR_W  debug address; sampled with request
- jtag_wdata_i  in  DATA_W  debug write data; sampled with request
- jtag_ack_o  out  1  debug op complete, one-cycle pulse
- jtag_rdata_o  out  DATA_W  debug read result, valid with ack and held
- rf_we_o  out  1  register-file write enable
- rf_waddr_o  out  ADDR_W  register-file write address
- rf_wdata_o  out  DATA_W  register-file write data
- rf_raddr_o  out  ADDR_W  register-file debug read address
- rf_rdata_i  in  DATA_W  register-file debug read data (combinational)
- hold_o  out  1  pipeline hold request
- init_done_o  out  1  zero-fill finished

## Operation
- States: INIT, IDLE, PEND, ACK, WAIT_REL.
- INIT:
  - An index counts 1..NUM_REGS-1, one per cycle.
  - Drives rf_we_o=1, rf_waddr_o=index, rf_wdata_o=0.
  - hold_o=1. ex writes and jtag_req_i are ignored.
  - After index NUM_REGS-1 is written: init_done_o=1 (sticky until rst), go to IDLE.
- Write port mux (IDLE/PEND/ACK/WAIT_REL):
  - An ex write is live when ex_we_i=1 and ex_waddr_i!=0. A live ex write passes through combinationally and always wins.
  - Otherwise the port carries the JTAG write in its service cycle, else rf_we_o=0.
- IDLE: jtag_req_i=1 captures we/addr/wdata into holding registers and moves to PEND.
- PEND:
  - Service cycle = the first cycle with no live ex write.
  - Write service: rf_we_o=1 with the captured addr/wdata. If the captured addr=0, nothing is written but the op is still acked.
  - Read service: rf_raddr_o=captured addr; rf_rdata_i is registered into jtag_rdata_o.
  - After service, go to ACK.
  - A starve counter increments on each PEND cycle lost to ex and saturates. hold_o=1 while counter ≥ STARVE_MAX and state is PEND.
- ACK: jtag_ack_o=1 for exactly this cycle, then WAIT_REL.
- WAIT_REL: when jtag_req_i=0, go to IDLE. A new request needs deassertion first.
- rf_raddr_o = captured addr in all states; 0 after reset.
- rst in any state: go to INIT, restart the fill at 1, drop any pending op (no ack).

## Timing
- Reset values: jtag_ack_o=0, jtag_rdata_o=0, init_done_o=0, hold_o=1 (INIT), rf_raddr_o=0, starve counter=0.
- Zero-fill takes NUM_REGS-1 cycles: init_done_o rises on cycle NUM_REGS-1 after rst is released (31 by default).
- ex path: zero-cycle latency, outputs combinational from ex_* inputs.
- JTAG: req seen at cycle t in IDLE → PEND at t+1 → earliest service at t+1 → ack at t+2. Each lost cycle adds 1.
- hold_o is registered: it rises the cycle after the counter reaches STARVE_MAX. It clears the cycle after the service cycle.
- A service cycle write and an ex write never coincide, so a debug read never overlaps a same-address ex write.

## Structure
- Shared package: state encoding, ZeroReg constant, ADDR_W/DATA_W defaults.
- Sub-module regs_init_seq: fill counter plus done flag, exposing we/addr/done.
- Starve counter and FSM stay in regs_port_arb.

## Test plan
- rst pulse → rf_we_o=1, addresses 1..31 with data 0, init_done_o=1 on cycle 31, hold_o low one cycle later.
- In IDLE, jtag write x5=0xDEADBEEF with no ex traffic → rf write at t+1, ack at t+2. A later jtag read of x5 → jtag_rdata_o=0xDEADBEEF with ack.
- ex_we_i=1 every cycle to x7 while jtag read x3 is pending → ex wins each cycle, hold_o rises after 4 lost cycles. Drop ex → read serviced, ack, hold_o clears.
- ex write to x0 concurrent with pending jtag write x9=0x1234 → jtag serviced that cycle; x0 is not a live ex write.
- jtag write x0=0xFFFFFFFF → rf_we_o stays 0, ack still pulses. jtag_req_i held high after ack → no second op until it drops.
- rst asserted while in PEND → no ack, FSM back to INIT, fill restarts at x1.

Source files
------------

// File: rtl/regs_port_arb_pkg.sv
// Shared definitions for the register-file write/debug port arbiter.
package regs_port_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ZeroReg    = 0;
  localparam int unsigned STARVE_W   = 4;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_PEND,
    S_ACK,
    S_WAIT_REL
  } state_t;

endpackage

// File: rtl/regs_init_seq.sv
// Post-reset zero-fill sequencer: walks addresses 1..NUM_REGS-1, one per cycle.
module regs_init_seq
  import regs_port_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);

  logic [ADDR_W-1:0] idx;

  // Fill index advances each cycle until the last register is written, then done sticks.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx  <= ADDR_W'(1);
      done <= 1'b0;
    end else if (!done) begin
      if (idx == LAST) begin
        done <= 1'b1;
      end else begin
        idx <= idx + ADDR_W'(1);
      end
    end
  end

  assign we   = !done;
  assign addr = idx;

endmodule

// File: rtl/regs_port_arb.sv
// Register-file write-port / debug-read-port sequencer and arbiter.
// ex write-back has fixed priority; JTAG uses a 4-phase req/ack handshake.
module regs_port_arb
  import regs_port_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_we_i,
  input  logic [ADDR_W-1:0] ex_waddr_i,
  input  logic [DATA_W-1:0] ex_wdata_i,
  input  logic              jtag_req_i,
  input  logic              jtag_we_i,
  input  logic [ADDR_W-1:0] jtag_addr_i,
  input  logic [DATA_W-1:0] jtag_wdata_i,
  output logic              jtag_ack_o,
  output logic [DATA_W-1:0] jtag_rdata_o,
  output logic              rf_we_o,
  output logic [ADDR_W-1:0] rf_waddr_o,
  output logic [DATA_W-1:0] rf_wdata_o,
  output logic [ADDR_W-1:0] rf_raddr_o,
  input  logic [DATA_W-1:0] rf_rdata_i,
  output logic              hold_o,
  output logic              init_done_o
);

  localparam logic [ADDR_W-1:0]   LAST       = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0]   ZERO_ADDR  = ADDR_W'(ZeroReg);
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  state_t              state;
  logic                cap_we;
  logic [ADDR_W-1:0]   cap_addr;
  logic [DATA_W-1:0]   cap_wdata;
  logic [STARVE_W-1:0] starve_cnt;

  logic              init_we;
  logic [ADDR_W-1:0] init_addr;
  logic              init_done;

  logic ex_live;
  logic service;

  regs_init_seq #(
    .ADDR_W  (ADDR_W),
    .NUM_REGS(NUM_REGS)
  ) u_init_seq (
    .clk (clk),
    .rst (rst),
    .we  (init_we),
    .addr(init_addr),
    .done(init_done)
  );

  assign ex_live     = ex_we_i && (ex_waddr_i != ZERO_ADDR);
  assign service     = (state == S_PEND) && !ex_live;
  assign rf_raddr_o  = cap_addr;
  assign init_done_o = init_done;

  // Write-port mux: zero-fill, then live ex write, then JTAG write in its service cycle.
  always_comb begin
    rf_we_o    = 1'b0;
    rf_waddr_o = '0;
    rf_wdata_o = '0;
    if (state == S_INIT) begin
      rf_we_o    = init_we;
      rf_waddr_o = init_addr;
    end else if (ex_live) begin
      rf_we_o    = 1'b1;
      rf_waddr_o = ex_waddr_i;
      rf_wdata_o = ex_wdata_i;
    end else if (service && cap_we && (cap_addr != ZERO_ADDR)) begin
      rf_we_o    = 1'b1;
      rf_waddr_o = cap_addr;
      rf_wdata_o = cap_wdata;
    end
  end

  // Handshake FSM with capture registers, starve counter and registered ack/rdata/hold.
  // hold_o looks at the current cycle's state, so it trails the counter by one cycle
  // and drops the cycle after the service cycle (or after the last fill cycle).
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_INIT;
      cap_we       <= 1'b0;
      cap_addr     <= '0;
      cap_wdata    <= '0;
      starve_cnt   <= '0;
      jtag_ack_o   <= 1'b0;
      jtag_rdata_o <= '0;
      hold_o       <= 1'b1;
    end else begin
      jtag_ack_o <= 1'b0;
      hold_o     <= (state == S_INIT) ||
                    ((state == S_PEND) && ex_live && (starve_cnt >= STARVE_LIM));
      case (state)
        S_INIT: begin
          if (init_we && (init_addr == LAST)) begin
            state <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (jtag_req_i) begin
            cap_we     <= jtag_we_i;
            cap_addr   <= jtag_addr_i;
            cap_wdata  <= jtag_wdata_i;
            starve_cnt <= '0;
            state      <= S_PEND;
          end
        end
        S_PEND: begin
          if (ex_live) begin
            if (starve_cnt != '1) begin
              starve_cnt <= starve_cnt + STARVE_W'(1);
            end
          end else begin
            if (!cap_we) begin
              jtag_rdata_o <= rf_rdata_i;
            end
            starve_cnt <= '0;
            jtag_ack_o <= 1'b1;
            state      <= S_ACK;
          end
        end
        S_ACK: begin
          state <= S_WAIT_REL;
        end
        S_WAIT_REL: begin
          if (!jtag_req_i) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regs_port_arb.sv
// Self-checking bench for regs_port_arb: write-port scoreboard plus handshake sequences.
module tb_regs_port_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_we_i = 1'b0;
  logic [4:0]  ex_waddr_i = '0;
  logic [31:0] ex_wdata_i = '0;
  logic        jtag_req_i = 1'b0;
  logic        jtag_we_i = 1'b0;
  logic [4:0]  jtag_addr_i = '0;
  logic [31:0] jtag_wdata_i = '0;
  logic        jtag_ack_o;
  logic [31:0] jtag_rdata_o;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic [4:0]  rf_raddr_o;
  logic [31:0] rf_rdata_i;
  logic        hold_o;
  logic        init_done_o;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;
  logic        mon_en = 1'b0;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic        ex_we;
    logic [4:0]  ex_addr;
    logic [31:0] ex_data;
    logic        exp_we;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
  } vec_t;

  wr_t         wr_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] rf_mem [32];

  always #5 clk = ~clk;

  regs_port_arb #(
    .ADDR_W    (5),
    .DATA_W    (32),
    .NUM_REGS  (32),
    .STARVE_MAX(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ex_we_i     (ex_we_i),
    .ex_waddr_i  (ex_waddr_i),
    .ex_wdata_i  (ex_wdata_i),
    .jtag_req_i  (jtag_req_i),
    .jtag_we_i   (jtag_we_i),
    .jtag_addr_i (jtag_addr_i),
    .jtag_wdata_i(jtag_wdata_i),
    .jtag_ack_o  (jtag_ack_o),
    .jtag_rdata_o(jtag_rdata_o),
    .rf_we_o     (rf_we_o),
    .rf_waddr_o  (rf_waddr_o),
    .rf_wdata_o  (rf_wdata_o),
    .rf_raddr_o  (rf_raddr_o),
    .rf_rdata_i  (rf_rdata_i),
    .hold_o      (hold_o),
    .init_done_o (init_done_o)
  );

  // Register-file stand-in: synchronous write, combinational debug read.
  always @(posedge clk) begin
    if (rf_we_o) rf_mem[rf_waddr_o] <= rf_wdata_o;
  end
  assign rf_rdata_i = rf_mem[rf_raddr_o];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_wr(input logic [4:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    wr_q.push_back(e);
  endtask

  // Every write the DUT issues must match the next expected write.
  always @(negedge clk) begin
    #4;
    if (mon_en && rf_we_o) begin
      if (wr_q.size() == 0) begin
        total_cnt++;
        $display("FAIL wr_unexpected: got addr %0d data %h expected no write at %0t",
                 rf_waddr_o, rf_wdata_o, $time);
      end else begin
        wr_t e;
        e = wr_q.pop_front();
        chk("wr_addr", 32'(rf_waddr_o), 32'(e.addr));
        chk("wr_data", rf_wdata_o, e.data);
      end
    end
  end

  task automatic check_ack_rdata();
    chk("ack", 32'(jtag_ack_o), 32'd1);
    if (rd_q.size() == 0) begin
      total_cnt++;
      $display("FAIL rd_q_empty: got no expected read expected one queued");
    end else begin
      chk("rd_data", jtag_rdata_o, rd_q.pop_front());
    end
  endtask

  // Release reset and follow the zero-fill through to hold_o dropping.
  task automatic run_fill();
    tick();
    rst    = 1'b0;
    mon_en = 1'b1;
    for (int a = 1; a < 32; a++) push_wr(5'(a), 32'd0);
    for (int k = 0; k <= 32; k++) begin
      if (k > 0) tick();
      #2;
      if (k == 0)  chk("fill_first_addr", 32'(rf_waddr_o), 32'd1);
      if (k == 0)  chk("fill_ack", 32'(jtag_ack_o), 32'd0);
      if (k == 30) chk("fill_done_early", 32'(init_done_o), 32'd0);
      if (k == 30) chk("fill_last_addr", 32'(rf_waddr_o), 32'd31);
      if (k == 31) chk("fill_done", 32'(init_done_o), 32'd1);
      if (k == 31) chk("fill_hold_still", 32'(hold_o), 32'd1);
      if (k == 32) chk("fill_hold_clear", 32'(hold_o), 32'd0);
    end
    chk("fill_q_drained", wr_q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    vecs[0] = '{1'b1, 5'd7,  32'h0000_0011, 1'b1, 5'd7,  32'h0000_0011};
    vecs[1] = '{1'b1, 5'd0,  32'h0000_0022, 1'b0, 5'd0,  32'h0};
    vecs[2] = '{1'b0, 5'd9,  32'h0000_0033, 1'b0, 5'd0,  32'h0};
    vecs[3] = '{1'b1, 5'd31, 32'hFFFF_FFFF, 1'b1, 5'd31, 32'hFFFF_FFFF};
    vecs[4] = '{1'b1, 5'd1,  32'h8000_0001, 1'b1, 5'd1,  32'h8000_0001};
    vecs[5] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0};

    // Reset values
    tick(); tick();
    #2;
    chk("rst_ack", 32'(jtag_ack_o), 32'd0);
    chk("rst_rdata", jtag_rdata_o, 32'd0);
    chk("rst_done", 32'(init_done_o), 32'd0);
    chk("rst_hold", 32'(hold_o), 32'd1);
    chk("rst_raddr", 32'(rf_raddr_o), 32'd0);

    run_fill();

    // ex pass-through in IDLE
    foreach (vecs[i]) begin
      tick();
      ex_we_i    = vecs[i].ex_we;
      ex_waddr_i = vecs[i].ex_addr;
      ex_wdata_i = vecs[i].ex_data;
      if (vecs[i].exp_we) push_wr(vecs[i].exp_addr, vecs[i].exp_data);
      #2;
      chk("vec_we", 32'(rf_we_o), 32'(vecs[i].exp_we));
      if (vecs[i].exp_we) begin
        chk("vec_addr", 32'(rf_waddr_o), 32'(vecs[i].exp_addr));
        chk("vec_data", rf_wdata_o, vecs[i].exp_data);
      end
    end

    // JTAG write x5 with no ex traffic
    tick();
    jtag_req_i = 1'b1; jtag_we_i = 1'b1; jtag_addr_i = 5'd5; jtag_wdata_i = 32'hDEAD_BEEF;
    push_wr(5'd5, 32'hDEAD_BEEF);
    #2 chk("jw_ack_t0", 32'(jtag_ack_o), 32'd0);
    tick(); #2;
    chk("jw_we_t1", 32'(rf_we_o), 32'd1);
    chk("jw_ack_t1", 32'(jtag_ack_o), 32'd0);
    tick(); #2;
    chk("jw_ack_t2", 32'(jtag_ack_o), 32'd1);
    chk("jw_hold", 32'(hold_o), 32'd0);
    tick(); jtag_req_i = 1'b0;
    #2 chk("jw_ack_t3", 32'(jtag_ack_o), 32'd0);
    tick();

    // JTAG read x5
    tick();
    jtag_req_i = 1'b1; jtag_we_i = 1'b0; jtag_addr_i = 5'd5;
    rd_q.push_back(32'hDEAD_BEEF);
    tick(); #2 chk("jr_raddr", 32'(rf_raddr_o), 32'd5);
    tick(); #2 check_ack_rdata();
    tick(); jtag_req_i = 1'b0;
    #2 chk("jr_rdata_held", jtag_rdata_o, 32'hDEAD_BEEF);
    tick();

    // Starvation: ex writes x7 every cycle while a read of x3 waits
    for (int c = 0; c < 8; c++) begin
      tick();
      if (c == 0) begin
        jtag_req_i = 1'b1; jtag_we_i = 1'b0; jtag_addr_i = 5'd3;
        rd_q.push_back(32'd0);
      end
      ex_we_i = 1'b1; ex_waddr_i = 5'd7; ex_wdata_i = 32'h100 + 32'(c);
      push_wr(5'd7, 32'h100 + 32'(c));
      #2;
      if (c == 5) chk("starve_hold_low", 32'(hold_o), 32'd0);
      if (c >= 6) chk("starve_hold_high", 32'(hold_o), 32'd1);
      if (c >= 1) chk("starve_no_ack", 32'(jtag_ack_o), 32'd0);
    end
    tick(); ex_we_i = 1'b0;
    #2;
    chk("starve_svc_hold", 32'(hold_o), 32'd1);
    chk("starve_raddr", 32'(rf_raddr_o), 32'd3);
    tick(); #2;
    check_ack_rdata();
    chk("starve_hold_clear", 32'(hold_o), 32'd0);
    tick(); jtag_req_i = 1'b0;
    tick();

    // ex write to x0 does not block a pending JTAG write
    tick();
    jtag_req_i = 1'b1; jtag_we_i = 1'b1; jtag_addr_i = 5'd9; jtag_wdata_i = 32'h1234;
    ex_we_i = 1'b1; ex_waddr_i = 5'd0; ex_wdata_i = 32'hBAD0_BAD0;
    push_wr(5'd9, 32'h1234);
    tick(); #2 chk("x0ex_addr", 32'(rf_waddr_o), 32'd9);
    tick(); ex_we_i = 1'b0;
    #2 chk("x0ex_ack", 32'(jtag_ack_o), 32'd1);
    tick(); jtag_req_i = 1'b0;
    tick();

    // JTAG write to x0: no write, still acked; held request gives no second op
    tick();
    jtag_req_i = 1'b1; jtag_we_i = 1'b1; jtag_addr_i = 5'd0; jtag_wdata_i = 32'hFFFF_FFFF;
    tick(); #2 chk("jx0_we", 32'(rf_we_o), 32'd0);
    tick(); #2 chk("jx0_ack", 32'(jtag_ack_o), 32'd1);
    for (int c = 0; c < 4; c++) begin
      tick(); #2 chk("jx0_held_no_ack", 32'(jtag_ack_o), 32'd0);
    end
    tick(); jtag_req_i = 1'b0;
    tick();

    // Reset while PEND: no ack, fill restarts at x1
    tick();
    jtag_req_i = 1'b1; jtag_we_i = 1'b1; jtag_addr_i = 5'd12; jtag_wdata_i = 32'h5555;
    ex_we_i = 1'b1; ex_waddr_i = 5'd7; ex_wdata_i = 32'h200;
    push_wr(5'd7, 32'h200);
    tick(); ex_wdata_i = 32'h201; push_wr(5'd7, 32'h201);
    #2 chk("rp_no_ack1", 32'(jtag_ack_o), 32'd0);
    tick(); rst = 1'b1; ex_wdata_i = 32'h202; push_wr(5'd7, 32'h202);
    #2 chk("rp_no_ack2", 32'(jtag_ack_o), 32'd0);
    tick(); mon_en = 1'b0; ex_we_i = 1'b0; jtag_req_i = 1'b0;
    #2;
    chk("rp_hold", 32'(hold_o), 32'd1);
    chk("rp_done", 32'(init_done_o), 32'd0);
    chk("rp_ack", 32'(jtag_ack_o), 32'd0);
    chk("rp_raddr", 32'(rf_raddr_o), 32'd0);
    run_fill();

    tick();
    chk("wr_q_empty", wr_q.size(), 32'd0);
    chk("rd_q_empty", rd_q.size(), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
